// File: rtl/cal_pkg.sv
// Shared calendar constants, BCD helpers and month-length/leap logic.
package cal_pkg;

  localparam int unsigned BCD_W = 8;

  // BCD month identifiers
  localparam logic [BCD_W-1:0] BCD_JAN = 8'h01;
  localparam logic [BCD_W-1:0] BCD_FEB = 8'h02;
  localparam logic [BCD_W-1:0] BCD_APR = 8'h04;
  localparam logic [BCD_W-1:0] BCD_JUN = 8'h06;
  localparam logic [BCD_W-1:0] BCD_SEP = 8'h09;
  localparam logic [BCD_W-1:0] BCD_NOV = 8'h11;
  localparam logic [BCD_W-1:0] BCD_DEC = 8'h12;

  // BCD month lengths
  localparam logic [BCD_W-1:0] LEN_31 = 8'h31;
  localparam logic [BCD_W-1:0] LEN_30 = 8'h30;
  localparam logic [BCD_W-1:0] LEN_29 = 8'h29;
  localparam logic [BCD_W-1:0] LEN_28 = 8'h28;

  // Counter endpoints
  localparam logic [BCD_W-1:0] DAY_FIRST  = 8'h01;
  localparam logic [BCD_W-1:0] YEAR_FIRST = 8'h00;
  localparam logic [BCD_W-1:0] YEAR_LAST  = 8'h99;

  // Reset defaults
  localparam logic [BCD_W-1:0] CAL_RST_YEAR  = 8'h00;
  localparam logic [BCD_W-1:0] CAL_RST_MONTH = 8'h01;
  localparam logic [BCD_W-1:0] CAL_RST_DAY   = 8'h01;

  typedef struct packed {
    logic             wrap;
    logic [BCD_W-1:0] val;
  } bcd_inc_t;

  // Leap when the two-digit year is a multiple of 4 (year 00 counts as leap)
  function automatic logic is_leap(input logic [BCD_W-1:0] year);
    return ((7'(year[7:4]) * 7'd10 + 7'(year[3:0])) % 7'd4) == 7'd0;
  endfunction

  // Number of days in a BCD month, as a BCD value
  function automatic logic [BCD_W-1:0] month_len(input logic [BCD_W-1:0] month,
                                                 input logic leap);
    logic [BCD_W-1:0] len;
    unique case (month)
      BCD_FEB:                          len = leap ? LEN_29 : LEN_28;
      BCD_APR, BCD_JUN, BCD_SEP, BCD_NOV: len = LEN_30;
      default:                          len = LEN_31;
    endcase
    return len;
  endfunction

  // Two-digit BCD increment; at 'last' wraps to 'first' and flags the wrap
  function automatic bcd_inc_t bcd_inc8(input logic [BCD_W-1:0] v,
                                        input logic [BCD_W-1:0] last,
                                        input logic [BCD_W-1:0] first);
    bcd_inc_t r;
    if (v == last) begin
      r.wrap = 1'b1;
      r.val  = first;
    end else if (v[3:0] == 4'h9) begin
      r.wrap = 1'b0;
      r.val  = {v[7:4] + 4'h1, 4'h0};
    end else begin
      r.wrap = 1'b0;
      r.val  = {v[7:4], v[3:0] + 4'h1};
    end
    return r;
  endfunction

endpackage

// File: rtl/date_validate.sv
// Combinational legality check of a preset date (BCD digits, month range, day range).
module date_validate
  import cal_pkg::*;
(
  input  logic [BCD_W-1:0] set_year,
  input  logic [BCD_W-1:0] set_month,
  input  logic [BCD_W-1:0] set_day,
  output logic             set_ok
);

  logic digits_ok;
  logic month_ok;
  logic day_ok;

  // Every nibble must be a decimal digit, then range-check month and day
  always_comb begin
    digits_ok = (set_year[7:4]  <= 4'h9) && (set_year[3:0]  <= 4'h9) &&
                (set_month[7:4] <= 4'h9) && (set_month[3:0] <= 4'h9) &&
                (set_day[7:4]   <= 4'h9) && (set_day[3:0]   <= 4'h9);
    month_ok  = (set_month >= BCD_JAN) && (set_month <= BCD_DEC);
    day_ok    = (set_day >= DAY_FIRST) &&
                (set_day <= month_len(set_month, is_leap(set_year)));
    set_ok    = digits_ok && month_ok && day_ok;
  end

endmodule

// File: rtl/date_calendar.sv
// BCD day/month/year calendar: advances on day_en, accepts validated presets,
// and pulses month_en/year_en on rollovers.
module date_calendar
  import cal_pkg::*;
#(
  parameter logic [7:0] RST_YEAR  = CAL_RST_YEAR,
  parameter logic [7:0] RST_MONTH = CAL_RST_MONTH,
  parameter logic [7:0] RST_DAY   = CAL_RST_DAY
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       day_en,
  input  logic       set_en,
  input  logic [7:0] set_year,
  input  logic [7:0] set_month,
  input  logic [7:0] set_day,
  output logic [3:0] year1,
  output logic [3:0] year0,
  output logic [3:0] month1,
  output logic [3:0] month0,
  output logic [3:0] day1,
  output logic [3:0] day0,
  output logic       month_en,
  output logic       year_en,
  output logic       set_err
);

  logic [BCD_W-1:0] year, month, day;
  logic [BCD_W-1:0] year_n, month_n, day_n;
  logic             month_en_n, year_en_n, set_err_n;
  logic             set_ok;
  bcd_inc_t         inc;

  date_validate u_validate (
    .set_year  (set_year),
    .set_month (set_month),
    .set_day   (set_day),
    .set_ok    (set_ok)
  );

  // Next-date logic: preset has priority over day advance; carries ripple day->month->year
  always_comb begin
    year_n     = year;
    month_n    = month;
    day_n      = day;
    month_en_n = 1'b0;
    year_en_n  = 1'b0;
    set_err_n  = 1'b0;
    inc        = '0;
    if (set_en) begin
      if (set_ok) begin
        year_n  = set_year;
        month_n = set_month;
        day_n   = set_day;
      end else begin
        set_err_n = 1'b1;
      end
    end else if (day_en) begin
      inc   = bcd_inc8(day, month_len(month, is_leap(year)), DAY_FIRST);
      day_n = inc.val;
      if (inc.wrap) begin
        inc        = bcd_inc8(month, BCD_DEC, BCD_JAN);
        month_n    = inc.val;
        month_en_n = 1'b1;
        if (inc.wrap) begin
          inc       = bcd_inc8(year, YEAR_LAST, YEAR_FIRST);
          year_n    = inc.val;
          year_en_n = 1'b1;
        end
      end
    end
  end

  // Date and pulse registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      year     <= RST_YEAR;
      month    <= RST_MONTH;
      day      <= RST_DAY;
      month_en <= 1'b0;
      year_en  <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      year     <= year_n;
      month    <= month_n;
      day      <= day_n;
      month_en <= month_en_n;
      year_en  <= year_en_n;
      set_err  <= set_err_n;
    end
  end

  assign year1  = year[7:4];
  assign year0  = year[3:0];
  assign month1 = month[7:4];
  assign month0 = month[3:0];
  assign day1   = day[7:4];
  assign day0   = day[3:0];

endmodule

// File: tb/tb_date_calendar.sv
// Directed self-checking bench for date_calendar (dates shown as YYMMDD BCD).
module tb_date_calendar;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       day_en;
  logic       set_en;
  logic [7:0] set_year, set_month, set_day;
  logic [3:0] year1, year0, month1, month0, day1, day0;
  logic       month_en, year_en, set_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] date;
  logic [2:0]  pulses;
  assign date   = {year1, year0, month1, month0, day1, day0};
  assign pulses = {month_en, year_en, set_err};

  localparam logic [23:0] BAD [5] = '{24'h230229, 24'h231301, 24'h230431,
                                      24'h230005, 24'h23011A};

  date_calendar dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .day_en   (day_en),
    .set_en   (set_en),
    .set_year (set_year),
    .set_month(set_month),
    .set_day  (set_day),
    .year1    (year1),
    .year0    (year0),
    .month1   (month1),
    .month0   (month0),
    .day1     (day1),
    .day0     (day0),
    .month_en (month_en),
    .year_en  (year_en),
    .set_err  (set_err)
  );

  always #5 clk_i = ~clk_i;

  // Drive a set pulse for one cycle; returns at the negedge after the update edge
  task automatic do_set(input logic [23:0] ymd, input logic with_day);
    @(negedge clk_i);
    {set_year, set_month, set_day} = ymd;
    set_en = 1'b1;
    day_en = with_day;
    @(negedge clk_i);
    set_en = 1'b0;
    day_en = 1'b0;
  endtask

  // Drive day_en for n consecutive cycles
  task automatic do_days(input int n);
    @(negedge clk_i);
    day_en = 1'b1;
    repeat (n) @(negedge clk_i);
    day_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; day_en = 1'b0; set_en = 1'b0;
    set_year = 8'h00; set_month = 8'h00; set_day = 8'h00;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    n_cmp++;
    if (date !== 24'h000101) begin n_err++; $display("FAIL reset_date: got %h want 000101", date); end
    n_cmp++;
    if (pulses !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", pulses); end
    for (int i = 0; i < 30; i++) begin
      do_days(1);
      n_cmp++;
      if (month_en !== 1'b0) begin n_err++; $display("FAIL jan_no_month_en: step %0d got %b want 0", i, month_en); end
    end
    n_cmp++;
    if (date !== 24'h000131) begin n_err++; $display("FAIL jan_31: got %h want 000131", date); end
  endtask

  task automatic test_month_rollover();
    do_set(24'h230430, 1'b0);
    n_cmp++;
    if ({date, pulses} !== {24'h230430, 3'b000}) begin n_err++; $display("FAIL set_230430: got %h/%b want 230430/000", date, pulses); end
    do_days(1);
    n_cmp++;
    if ({date, pulses} !== {24'h230501, 3'b100}) begin n_err++; $display("FAIL apr_roll: got %h/%b want 230501/100", date, pulses); end
    @(negedge clk_i);
    n_cmp++;
    if (pulses !== 3'b000) begin n_err++; $display("FAIL apr_roll_pulse_len: got %b want 000", pulses); end
    do_set(24'h230930, 1'b0);
    do_days(1);
    n_cmp++;
    if ({date, pulses} !== {24'h231001, 3'b100}) begin n_err++; $display("FAIL sep_roll: got %h/%b want 231001/100", date, pulses); end
  endtask

  task automatic test_leap_feb();
    do_set(24'h240228, 1'b0);
    do_days(1);
    n_cmp++;
    if ({date, pulses} !== {24'h240229, 3'b000}) begin n_err++; $display("FAIL leap_29: got %h/%b want 240229/000", date, pulses); end
    do_days(1);
    n_cmp++;
    if ({date, pulses} !== {24'h240301, 3'b100}) begin n_err++; $display("FAIL leap_roll: got %h/%b want 240301/100", date, pulses); end
    do_set(24'h230228, 1'b0);
    do_days(1);
    n_cmp++;
    if ({date, pulses} !== {24'h230301, 3'b100}) begin n_err++; $display("FAIL nonleap_roll: got %h/%b want 230301/100", date, pulses); end
    do_set(24'h000229, 1'b0);
    n_cmp++;
    if ({date, pulses} !== {24'h000229, 3'b000}) begin n_err++; $display("FAIL y00_leap_set: got %h/%b want 000229/000", date, pulses); end
  endtask

  task automatic test_year_wrap();
    do_set(24'h991231, 1'b0);
    do_days(1);
    n_cmp++;
    if ({date, pulses} !== {24'h000101, 3'b110}) begin n_err++; $display("FAIL year_wrap: got %h/%b want 000101/110", date, pulses); end
    @(negedge clk_i);
    n_cmp++;
    if (pulses !== 3'b000) begin n_err++; $display("FAIL year_wrap_pulse_len: got %b want 000", pulses); end
  endtask

  task automatic test_invalid_set();
    do_set(24'h230615, 1'b0);
    for (int i = 0; i < 5; i++) begin
      do_set(BAD[i], 1'b0);
      n_cmp++;
      if ({date, pulses} !== {24'h230615, 3'b001}) begin n_err++; $display("FAIL bad_set_%h: got %h/%b want 230615/001", BAD[i], date, pulses); end
      @(negedge clk_i);
      n_cmp++;
      if (set_err !== 1'b0) begin n_err++; $display("FAIL bad_set_err_len_%h: got %b want 0", BAD[i], set_err); end
    end
  endtask

  task automatic test_day_held();
    do_days(3);
    n_cmp++;
    if (date !== 24'h230618) begin n_err++; $display("FAIL day_held_3: got %h want 230618", date); end
  endtask

  task automatic test_collision();
    do_set(24'h230101, 1'b0);
    do_set(24'h230615, 1'b1);
    n_cmp++;
    if ({date, pulses} !== {24'h230615, 3'b000}) begin n_err++; $display("FAIL set_vs_day: got %h/%b want 230615/000", date, pulses); end
    do_set(24'h230229, 1'b1);
    n_cmp++;
    if ({date, pulses} !== {24'h230615, 3'b001}) begin n_err++; $display("FAIL badset_vs_day: got %h/%b want 230615/001", date, pulses); end
  endtask

  task automatic test_reset_priority();
    @(negedge clk_i);
    rst_i = 1'b1; set_en = 1'b1; day_en = 1'b1;
    {set_year, set_month, set_day} = 24'h230229;
    @(negedge clk_i);
    rst_i = 1'b0; set_en = 1'b0; day_en = 1'b0;
    n_cmp++;
    if ({date, pulses} !== {24'h000101, 3'b000}) begin n_err++; $display("FAIL reset_priority: got %h/%b want 000101/000", date, pulses); end
  endtask

  initial begin
    test_reset();
    test_month_rollover();
    test_leap_feb();
    test_year_wrap();
    test_invalid_set();
    test_day_held();
    test_collision();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
